pipeline_control_unit: RTL and testbench

Pipelined control and hazard block for the 5-stage RISC-V core. It decodes the 3-bit opcode in ID and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers. It also detects load-use hazards (stall plus bubble), flushes on a taken `beq`, and generates EX-stage forwarding selects. Saturating stall and flush counters support performance debug. It replaces the single-cycle control unit next to the datapath in the processor top.

---
 rtl/riscv_pipe_pkg.sv | 98 +++++++++
 rtl/pipeline_control_unit_hazard_unit.sv | 71 +++++++
 rtl/pipeline_control_unit.sv | 159 +++++++++++++++
 tb/tb_pipeline_control_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg
//   Shared types and constants for the pipelined control path of the
//   5-stage RISC-V core: opcode encoding, the control bundle carried down
//   the pipeline, the bubble value and the forwarding select encodings.
//   decode_instr() turns an ID-stage opcode into its control bundle and
//   reports which source registers the instruction actually reads.
package riscv_pipe_pkg;

  typedef enum logic [2:0] {
    OP_RTYPE = 3'b000,
    OP_ITYPE = 3'b001,
    OP_LOAD  = 3'b010,
    OP_STORE = 3'b011,
    OP_BEQ   = 3'b100
  } opcode_e;

  typedef struct packed {
    logic       alu_src;
    logic [1:0] alu_op;
    logic       beq;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // ALU operation classes handed to the ALU control in EX
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
  localparam logic [1:0] ALU_OP_ITYPE = 2'b11;

  // ALU operand source selects
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef struct packed {
    ctrl_t ctrl;
    logic  uses_rs1;
    logic  uses_rs2;
  } decode_t;

  // Invalid slots and unassigned opcodes decode to a bubble that reads no
  // registers, so they can never trigger a load-use stall.
  function automatic decode_t decode_instr(input logic valid, input logic [2:0] opcode);
    decode_t d;
    d.ctrl     = CTRL_BUBBLE;
    d.uses_rs1 = 1'b0;
    d.uses_rs2 = 1'b0;
    if (valid) begin
      case (opcode_e'(opcode))
        OP_RTYPE: begin
          d.ctrl.reg_write = 1'b1;
          d.ctrl.alu_op    = ALU_OP_RTYPE;
          d.uses_rs1       = 1'b1;
          d.uses_rs2       = 1'b1;
        end
        OP_ITYPE: begin
          d.ctrl.alu_src   = 1'b1;
          d.ctrl.reg_write = 1'b1;
          d.ctrl.alu_op    = ALU_OP_ITYPE;
          d.uses_rs1       = 1'b1;
        end
        OP_LOAD: begin
          d.ctrl.alu_src    = 1'b1;
          d.ctrl.mem_read   = 1'b1;
          d.ctrl.mem_to_reg = 1'b1;
          d.ctrl.reg_write  = 1'b1;
          d.ctrl.alu_op     = ALU_OP_ADD;
          d.uses_rs1        = 1'b1;
        end
        OP_STORE: begin
          d.ctrl.alu_src   = 1'b1;
          d.ctrl.mem_write = 1'b1;
          d.ctrl.alu_op    = ALU_OP_ADD;
          d.uses_rs1       = 1'b1;
          d.uses_rs2       = 1'b1;
        end
        OP_BEQ: begin
          d.ctrl.beq    = 1'b1;
          d.ctrl.alu_op = ALU_OP_SUB;
          d.uses_rs1    = 1'b1;
          d.uses_rs2    = 1'b1;
        end
        default: begin
          d.ctrl     = CTRL_BUBBLE;
          d.uses_rs1 = 1'b0;
          d.uses_rs2 = 1'b0;
        end
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/pipeline_control_unit_hazard_unit.sv
// hazard_unit
//   Purely combinational hazard logic for the 5-stage pipeline.
//   Inputs : ID-stage source fields and their use flags, the ID/EX load
//            flag, destination and sources, the branch flag with the ALU
//            zero flag, and the EX/MEM and MEM/WB write-back info.
//   Outputs: pc_stall / ifid_flush to the fetch side, idex_bubble to squash
//            the ID/EX input, and fwd_a / fwd_b ALU operand selects.
module hazard_unit
  import riscv_pipe_pkg::*;
#(
  parameter int RegAddrBits = 5
) (
  input  logic [RegAddrBits-1:0] id_rs1,
  input  logic [RegAddrBits-1:0] id_rs2,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic                   ex_mem_read,
  input  logic                   ex_beq,
  input  logic                   ex_zero,
  input  logic [RegAddrBits-1:0] ex_rs1,
  input  logic [RegAddrBits-1:0] ex_rs2,
  input  logic [RegAddrBits-1:0] ex_rd,
  input  logic                   exmem_reg_write,
  input  logic [RegAddrBits-1:0] exmem_rd,
  input  logic                   memwb_reg_write,
  input  logic [RegAddrBits-1:0] memwb_rd,
  output logic                   pc_stall,
  output logic                   ifid_flush,
  output logic                   idex_bubble,
  output logic [1:0]             fwd_a,
  output logic [1:0]             fwd_b
);

  logic branch_taken;
  logic load_use;

  // The younger EX/MEM result wins over MEM/WB; x0 is never forwarded.
  function automatic logic [1:0] fwd_select(
    input logic [RegAddrBits-1:0] src,
    input logic                   m_write,
    input logic [RegAddrBits-1:0] m_rd,
    input logic                   w_write,
    input logic [RegAddrBits-1:0] w_rd
  );
    if (m_write && (m_rd != '0) && (m_rd == src)) begin
      return FWD_EXMEM;
    end else if (w_write && (w_rd != '0) && (w_rd == src)) begin
      return FWD_MEMWB;
    end
    return FWD_REG;
  endfunction

  // A taken branch squashes the ID instruction anyway, so it masks any
  // load-use stall raised in the same cycle; both cases bubble ID/EX.
  always_comb begin
    branch_taken = ex_beq & ex_zero;
    load_use     = ex_mem_read && (ex_rd != '0) &&
                   ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                    (id_uses_rs2 && (id_rs2 == ex_rd)));
    ifid_flush   = branch_taken;
    pc_stall     = load_use & ~branch_taken;
    idex_bubble  = load_use | branch_taken;
  end

  // Operand selects for the instruction currently in EX.
  always_comb begin
    fwd_a = fwd_select(ex_rs1, exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd);
    fwd_b = fwd_select(ex_rs2, exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd);
  end

endmodule

// File: rtl/pipeline_control_unit.sv
// pipeline_control_unit
//   Decodes the ID-stage opcode, carries the control bundle through the
//   ID/EX, EX/MEM and MEM/WB registers, and uses hazard_unit for load-use
//   stalls, taken-branch flushes and EX-stage forwarding.
//   Inputs : clk, rst (async, active high), id_valid, id_opcode, id_rs1,
//            id_rs2, id_rd, ex_zero.
//   Outputs: pc_stall, ifid_flush, ex_* (EX controls), mem_* (MEM controls),
//            wb_* and wb_rd (write-back), fwd_a/fwd_b, and the saturating
//            stall_count / flush_count performance counters.
module pipeline_control_unit
  import riscv_pipe_pkg::*;
#(
  parameter  int N           = 32,
  parameter  int CountBits   = 16,
  localparam int RegAddrBits = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [2:0]             id_opcode,
  input  logic [RegAddrBits-1:0] id_rs1,
  input  logic [RegAddrBits-1:0] id_rs2,
  input  logic [RegAddrBits-1:0] id_rd,
  input  logic                   ex_zero,
  output logic                   pc_stall,
  output logic                   ifid_flush,
  output logic                   ex_alu_src,
  output logic [1:0]             ex_alu_op,
  output logic                   ex_beq,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   wb_reg_write,
  output logic                   wb_mem_to_reg,
  output logic [RegAddrBits-1:0] wb_rd,
  output logic [1:0]             fwd_a,
  output logic [1:0]             fwd_b,
  output logic [CountBits-1:0]   stall_count,
  output logic [CountBits-1:0]   flush_count
);

  decode_t                id_dec;
  logic                   idex_bubble;

  ctrl_t                  idex_ctrl;
  logic [RegAddrBits-1:0] idex_rs1;
  logic [RegAddrBits-1:0] idex_rs2;
  logic [RegAddrBits-1:0] idex_rd;

  logic                   exmem_mem_read;
  logic                   exmem_mem_write;
  logic                   exmem_mem_to_reg;
  logic                   exmem_reg_write;
  logic [RegAddrBits-1:0] exmem_rd;

  logic                   memwb_reg_write;
  logic                   memwb_mem_to_reg;
  logic [RegAddrBits-1:0] memwb_rd;

  localparam logic [CountBits-1:0] CountMax = '1;

  // ID-stage decode of the instruction sitting in IF/ID.
  always_comb begin
    id_dec = decode_instr(id_valid, id_opcode);
  end

  hazard_unit #(
    .RegAddrBits(RegAddrBits)
  ) u_hazard (
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_uses_rs1    (id_dec.uses_rs1),
    .id_uses_rs2    (id_dec.uses_rs2),
    .ex_mem_read    (idex_ctrl.mem_read),
    .ex_beq         (idex_ctrl.beq),
    .ex_zero        (ex_zero),
    .ex_rs1         (idex_rs1),
    .ex_rs2         (idex_rs2),
    .ex_rd          (idex_rd),
    .exmem_reg_write(exmem_reg_write),
    .exmem_rd       (exmem_rd),
    .memwb_reg_write(memwb_reg_write),
    .memwb_rd       (memwb_rd),
    .pc_stall       (pc_stall),
    .ifid_flush     (ifid_flush),
    .idex_bubble    (idex_bubble),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b)
  );

  // ID/EX register. A squashed slot becomes a full NOP, register fields
  // included, so a bubble looks exactly like the post-reset state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_ctrl <= CTRL_BUBBLE;
      idex_rs1  <= '0;
      idex_rs2  <= '0;
      idex_rd   <= '0;
    end else if (idex_bubble) begin
      idex_ctrl <= CTRL_BUBBLE;
      idex_rs1  <= '0;
      idex_rs2  <= '0;
      idex_rd   <= '0;
    end else begin
      idex_ctrl <= id_dec.ctrl;
      idex_rs1  <= id_rs1;
      idex_rs2  <= id_rs2;
      idex_rd   <= id_rd;
    end
  end

  // EX/MEM and MEM/WB registers keep only the bits still needed downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exmem_mem_read   <= 1'b0;
      exmem_mem_write  <= 1'b0;
      exmem_mem_to_reg <= 1'b0;
      exmem_reg_write  <= 1'b0;
      exmem_rd         <= '0;
      memwb_reg_write  <= 1'b0;
      memwb_mem_to_reg <= 1'b0;
      memwb_rd         <= '0;
    end else begin
      exmem_mem_read   <= idex_ctrl.mem_read;
      exmem_mem_write  <= idex_ctrl.mem_write;
      exmem_mem_to_reg <= idex_ctrl.mem_to_reg;
      exmem_reg_write  <= idex_ctrl.reg_write;
      exmem_rd         <= idex_rd;
      memwb_reg_write  <= exmem_reg_write;
      memwb_mem_to_reg <= exmem_mem_to_reg;
      memwb_rd         <= exmem_rd;
    end
  end

  // Saturating event counters; a stall masked by a flush is not counted
  // because pc_stall is already low in that case.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (pc_stall && (stall_count != CountMax)) begin
        stall_count <= stall_count + CountBits'(1);
      end
      if (ifid_flush && (flush_count != CountMax)) begin
        flush_count <= flush_count + CountBits'(1);
      end
    end
  end

  assign ex_alu_src    = idex_ctrl.alu_src;
  assign ex_alu_op     = idex_ctrl.alu_op;
  assign ex_beq        = idex_ctrl.beq;
  assign mem_read      = exmem_mem_read;
  assign mem_write     = exmem_mem_write;
  assign wb_reg_write  = memwb_reg_write;
  assign wb_mem_to_reg = memwb_mem_to_reg;
  assign wb_rd         = memwb_rd;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// tb_pipeline_control_unit
//   Drives an instruction stream into two copies of pipeline_control_unit
//   (default counters and 2-bit counters) and compares every output against
//   an instruction-level model of the pipeline kept in the bench.
module tb_pipeline_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [2:0] id_opcode;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_zero;

  logic        pc_stall, ifid_flush, ex_alu_src, ex_beq, mem_read, mem_write;
  logic        wb_reg_write, wb_mem_to_reg;
  logic [1:0]  ex_alu_op, fwd_a, fwd_b;
  logic [4:0]  wb_rd;
  logic [15:0] stall_count, flush_count;

  logic        s_pc_stall, s_ifid_flush, s_ex_alu_src, s_ex_beq, s_mem_read, s_mem_write;
  logic        s_wb_reg_write, s_wb_mem_to_reg;
  logic [1:0]  s_ex_alu_op, s_fwd_a, s_fwd_b;
  logic [4:0]  s_wb_rd;
  logic [1:0]  s_stall_count, s_flush_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_control_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_zero(ex_zero),
    .pc_stall(pc_stall), .ifid_flush(ifid_flush), .ex_alu_src(ex_alu_src),
    .ex_alu_op(ex_alu_op), .ex_beq(ex_beq), .mem_read(mem_read),
    .mem_write(mem_write), .wb_reg_write(wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  pipeline_control_unit #(.CountBits(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_zero(ex_zero),
    .pc_stall(s_pc_stall), .ifid_flush(s_ifid_flush), .ex_alu_src(s_ex_alu_src),
    .ex_alu_op(s_ex_alu_op), .ex_beq(s_ex_beq), .mem_read(s_mem_read),
    .mem_write(s_mem_write), .wb_reg_write(s_wb_reg_write),
    .wb_mem_to_reg(s_wb_mem_to_reg), .wb_rd(s_wb_rd), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
    .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  typedef struct packed {
    logic       valid;
    logic [2:0] op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } instr_t;

  // Model state: the instruction occupying each stage, and event totals.
  instr_t m_ex, m_mem, m_wb;
  int     m_stalls, m_flushes;
  logic   last_stall, last_flush;
  instr_t prog[$];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic instr_t mk(input int op, input int rs1, input int rs2, input int rd);
    instr_t i;
    i.valid = 1'b1;
    i.op    = 3'(op);
    i.rs1   = 5'(rs1);
    i.rs2   = 5'(rs2);
    i.rd    = 5'(rd);
    return i;
  endfunction

  function automatic logic is_op(input instr_t i, input int code);
    return i.valid && (int'(i.op) == code);
  endfunction

  function automatic logic writes_reg(input instr_t i);
    return is_op(i, 0) || is_op(i, 1) || is_op(i, 2);
  endfunction

  function automatic logic reads_rs1(input instr_t i);
    return i.valid && (int'(i.op) <= 4);
  endfunction

  function automatic logic reads_rs2(input instr_t i);
    return is_op(i, 0) || is_op(i, 3) || is_op(i, 4);
  endfunction

  function automatic logic [1:0] model_alu_op(input instr_t i);
    if (is_op(i, 0)) return 2'b10;
    if (is_op(i, 1)) return 2'b11;
    if (is_op(i, 4)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] src);
    if (writes_reg(m_mem) && m_mem.rd != 0 && m_mem.rd == src) return 2'b10;
    if (writes_reg(m_wb) && m_wb.rd != 0 && m_wb.rd == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_ctl"}, 32'({pc_stall, ifid_flush, ex_alu_src, ex_alu_op, ex_beq,
                 mem_read, mem_write, wb_reg_write, wb_mem_to_reg, wb_rd, fwd_a, fwd_b}), 0);
    checkOutput({tag, "_cnt"}, {stall_count, flush_count}, 0);
    checkOutput({tag, "_sat"}, 32'({s_pc_stall, s_ifid_flush, s_ex_alu_src, s_ex_alu_op,
                 s_ex_beq, s_mem_read, s_mem_write, s_wb_reg_write, s_wb_mem_to_reg,
                 s_wb_rd, s_fwd_a, s_fwd_b, s_stall_count, s_flush_count}), 0);
  endtask

  task automatic model_reset();
    m_ex = '0; m_mem = '0; m_wb = '0;
    m_stalls = 0; m_flushes = 0;
    last_stall = 1'b0; last_flush = 1'b0;
  endtask

  // One clock cycle: check registered outputs, drive ID, check the
  // combinational hazard outputs, then advance the model.
  task automatic applyStimulus(input instr_t ins, input logic zero);
    logic tk, hz;
    @(negedge clk);
    checkOutput("ex_alu_src", ex_alu_src, is_op(m_ex, 1) || is_op(m_ex, 2) || is_op(m_ex, 3));
    checkOutput("ex_alu_op", ex_alu_op, model_alu_op(m_ex));
    checkOutput("ex_beq", ex_beq, is_op(m_ex, 4));
    checkOutput("mem_read", mem_read, is_op(m_mem, 2));
    checkOutput("mem_write", mem_write, is_op(m_mem, 3));
    checkOutput("wb_reg_write", wb_reg_write, writes_reg(m_wb));
    checkOutput("wb_mem_to_reg", wb_mem_to_reg, is_op(m_wb, 2));
    checkOutput("wb_rd", wb_rd, m_wb.rd);
    checkOutput("fwd_a", fwd_a, model_fwd(m_ex.rs1));
    checkOutput("fwd_b", fwd_b, model_fwd(m_ex.rs2));
    checkOutput("stall_count", stall_count, sat(m_stalls, 65535));
    checkOutput("flush_count", flush_count, sat(m_flushes, 65535));
    checkOutput("sat_stall_count", s_stall_count, sat(m_stalls, 3));
    checkOutput("sat_flush_count", s_flush_count, sat(m_flushes, 3));
    id_valid  = ins.valid;
    id_opcode = ins.op;
    id_rs1    = ins.rs1;
    id_rs2    = ins.rs2;
    id_rd     = ins.rd;
    ex_zero   = zero;
    #1;
    tk = is_op(m_ex, 4) && zero;
    hz = is_op(m_ex, 2) && (m_ex.rd != 0) &&
         ((reads_rs1(ins) && ins.rs1 == m_ex.rd) || (reads_rs2(ins) && ins.rs2 == m_ex.rd));
    checkOutput("pc_stall", pc_stall, hz && !tk);
    checkOutput("ifid_flush", ifid_flush, tk);
    checkOutput("sat_pc_stall", s_pc_stall, hz && !tk);
    last_stall = hz && !tk;
    last_flush = tk;
    m_wb  = m_mem;
    m_mem = m_ex;
    m_ex  = (tk || hz) ? instr_t'('0) : ins;
    if (tk) m_flushes++;
    else if (hz) m_stalls++;
  endtask

  // Asynchronous reset in the middle of a cycle, then restart from a NOP.
  task automatic mid_reset();
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    id_valid = 1'b0; id_opcode = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0; ex_zero = 1'b0;
    model_reset();
  endtask

  function automatic instr_t next_fetch();
    if (prog.size() != 0) return prog.pop_front();
    return '0;
  endfunction

  // Plays prog like a fetch unit: hold on stall, NOP after a flush.
  // zmode: 0 = ex_zero low, 1 = ex_zero high, 2 = random.
  task automatic run_prog(input int zmode, input int reset_at);
    instr_t cur;
    int     cyc;
    logic   z;
    cur = next_fetch();
    cyc = 0;
    while ((prog.size() != 0 || cur.valid) && cyc < 5000) begin
      z = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      applyStimulus(cur, z);
      if (cyc == reset_at) begin
        mid_reset();
        cur = '0;
      end else if (last_stall) begin
        cur = cur;
      end else if (last_flush) begin
        cur = '0;
      end else begin
        cur = next_fetch();
      end
      cyc++;
    end
    repeat (4) applyStimulus('0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    id_valid = 1'b0; id_opcode = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0; ex_zero = 1'b0;
    model_reset();
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] decode latency: load rd=5");
    prog = '{mk(2, 1, 0, 5)};
    run_prog(0, -1);

    $display("[TB] forwarding chain, then the same chain through x0");
    prog = '{mk(0, 2, 3, 1), mk(0, 1, 4, 6), mk(1, 1, 0, 7),
             mk(0, 2, 3, 0), mk(0, 0, 4, 6), mk(1, 0, 0, 7)};
    run_prog(0, -1);

    $display("[TB] load-use stall");
    prog = '{mk(2, 1, 0, 5), mk(0, 3, 5, 6), mk(2, 2, 0, 0), mk(0, 0, 0, 4)};
    run_prog(0, -1);

    $display("[TB] beq taken, then not taken");
    prog = '{mk(4, 1, 2, 0), mk(0, 1, 2, 3), mk(1, 3, 0, 4)};
    run_prog(1, -1);
    prog = '{mk(4, 1, 2, 0), mk(0, 1, 2, 3), mk(1, 3, 0, 4)};
    run_prog(0, -1);

    $display("[TB] random stream with a mid-stream reset");
    for (int i = 0; i < 600; i++) begin
      instr_t r;
      r       = mk($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      r.valid = ($urandom_range(0, 9) != 0);
      prog.push_back(r);
    end
    run_prog(2, 300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
